// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared accumulator widths, decoded-op record and decoder state
package acc_pkg;

  localparam int ACC_W_DEFAULT  = 16;
  localparam int DATA_W_DEFAULT = 8;

  // One decoded accumulator operation: 0 = add, 1 = subtract
  typedef struct packed {
    logic                      add_sub;
    logic [DATA_W_DEFAULT-1:0] data;
  } op_t;

  // RESYNC swallows one sample after an undecodable jump
  typedef enum logic {
    RUN    = 1'b0,
    RESYNC = 1'b1
  } dec_state_t;

endpackage

// File: rtl/acc_delta_decoder_op_fifo2.sv
// rtl/acc_delta_decoder_op_fifo2.sv - two-entry registered FIFO for decoded ops
module op_fifo2
  import acc_pkg::*;
#(
  parameter int W = $bits(op_t)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] s_tdata,
  input  logic         s_tvalid,
  output logic [W-1:0] m_tdata,
  input  logic         m_tready,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  // Writer is refused while full, so a full FIFO can only pop this cycle
  assign push    = s_tvalid && !full;
  assign pop     = !empty && m_tready;
  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign m_tdata = mem[rd_ptr];

  // Storage, pointers and occupancy; reset clears the entries so the head reads zero
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s_tdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/acc_delta_decoder.sv
// rtl/acc_delta_decoder.sv - recovers add/sub operations from a stream of accumulator values
module acc_delta_decoder
  import acc_pkg::*;
#(
  parameter int               ACC_W    = ACC_W_DEFAULT,
  parameter int               DATA_W   = DATA_W_DEFAULT,
  parameter logic [ACC_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ACC_W-1:0]  acc_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              add_sub,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err,
  output logic [7:0]        err_count
);

  logic [ACC_W-1:0] prev;
  logic [ACC_W-1:0] d;
  logic [ACC_W-1:0] n;
  dec_state_t       state;
  logic             accept;
  logic             fits_add;
  logic             fits_sub;
  logic             push;
  logic [DATA_W:0]  push_op;
  logic [DATA_W:0]  head_op;
  logic             fifo_full;
  logic             fifo_empty;

  // Forward and backward distances mod 2^ACC_W; an operand fits when no bits sit above DATA_W
  assign in_ready = !fifo_full;
  assign accept   = in_valid && in_ready;
  assign d        = acc_in - prev;
  assign n        = prev - acc_in;
  assign fits_add = ((d >> DATA_W) == '0);
  assign fits_sub = ((n >> DATA_W) == '0);
  assign push     = accept && (state == RUN) && (fits_add || fits_sub);
  assign push_op  = fits_add ? {1'b0, d[DATA_W-1:0]} : {1'b1, n[DATA_W-1:0]};

  assign out_valid           = !fifo_empty;
  assign {add_sub, data_out} = head_op;

  // Previous sample, resync state machine and sticky error bookkeeping
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev      <= INIT_VAL;
      state     <= RUN;
      err       <= 1'b0;
      err_count <= 8'd0;
    end else if (accept) begin
      prev <= acc_in;
      if (state == RESYNC) begin
        state <= RUN;
      end else if (!(fits_add || fits_sub)) begin
        err   <= 1'b1;
        state <= RESYNC;
        if (err_count != 8'hFF) begin
          err_count <= err_count + 8'd1;
        end
      end
    end
  end

  op_fifo2 #(
    .W(DATA_W + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (push_op),
    .s_tvalid (push),
    .m_tdata  (head_op),
    .m_tready (out_ready),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_acc_delta_decoder.sv
// tb/tb_acc_delta_decoder.sv - randomized and directed checks of acc_delta_decoder against a queue model
module tb_acc_delta_decoder;
  import acc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] acc_in;
  logic        in_valid;
  logic        in_ready;
  logic        add_sub;
  logic [7:0]  data_out;
  logic        out_valid;
  logic        out_ready;
  logic        err;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  acc_delta_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .acc_in    (acc_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .add_sub   (add_sub),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .err_count (err_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  op_t         mq[$];
  op_t         seen[$];
  logic [15:0] pending[$];
  int          mprev;
  bit          mresync;
  bit          merr;
  int          mcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic op_t op(input bit s, input int v);
    op_t o;
    o.add_sub = s;
    o.data    = 8'(v);
    return o;
  endfunction

  function automatic void model_accept(input int v);
    int fwd;
    int bwd;
    fwd = (v - mprev) & 16'hFFFF;
    bwd = (mprev - v) & 16'hFFFF;
    if (mresync) mresync = 1'b0;
    else if (fwd < 256) mq.push_back(op(1'b0, fwd));
    else if (bwd < 256) mq.push_back(op(1'b1, bwd));
    else begin
      merr    = 1'b1;
      mresync = 1'b1;
      if (mcnt < 255) mcnt++;
    end
    mprev = v;
  endfunction

  task automatic step();
    bit macc;
    bit mpop;
    in_valid = (pending.size() > 0);
    acc_in   = in_valid ? pending[0] : 16'($urandom);
    chk("in_ready", in_ready, mq.size() < 2);
    chk("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("add_sub", add_sub, mq[0].add_sub);
      chk("data_out", data_out, mq[0].data);
    end
    chk("err", err, merr);
    chk("err_count", err_count, mcnt);
    if (out_valid && out_ready) seen.push_back(op(add_sub, data_out));
    macc = in_valid && (mq.size() < 2);
    mpop = (mq.size() > 0) && out_ready;
    @(posedge clk);
    if (mpop) void'(mq.pop_front());
    if (macc) model_accept(pending.pop_front());
    @(negedge clk);
  endtask

  task automatic run_until_idle(input int budget);
    int k = 0;
    while ((pending.size() > 0 || mq.size() > 0) && k < budget) begin
      step();
      k++;
    end
    if (pending.size() > 0 || mq.size() > 0) chk("idle_timeout", 0, 1);
    step();
  endtask

  task automatic check_seen(input string tag, input op_t e[$]);
    chk({tag, "_count"}, seen.size(), e.size());
    for (int i = 0; i < e.size() && i < seen.size(); i++) chk(tag, seen[i], e[i]);
    seen.delete();
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    mq.delete();
    pending.delete();
    seen.delete();
    mprev   = 0;
    mresync = 1'b0;
    merr    = 1'b0;
    mcnt    = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_add_sub", add_sub, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_err", err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    op_t         e[$];
    logic [15:0] last;
    rst       = 1'b0;
    in_valid  = 1'b0;
    acc_in    = '0;
    out_ready = 1'b1;
    @(negedge clk);
    do_reset();

    pending = {16'h0005, 16'h000F, 16'h000C, 16'h0008};
    run_until_idle(100);
    e = {op(0, 5), op(0, 10), op(1, 3), op(1, 4)};
    check_seen("basic", e);
    chk("basic_err", err, 0);

    do_reset();
    pending = {16'hFFFE, 16'h0003, 16'hFFFF};
    run_until_idle(100);
    e = {op(1, 2), op(0, 5), op(1, 4)};
    check_seen("wrap", e);

    do_reset();
    out_ready = 1'b0;
    pending = {16'h0001, 16'h0002, 16'h0003};
    repeat (4) step();
    chk("bp_in_ready", in_ready, 0);
    chk("bp_left", pending.size(), 1);
    out_ready = 1'b1;
    run_until_idle(100);
    e = {op(0, 1), op(0, 1), op(0, 1)};
    check_seen("bp", e);

    do_reset();
    pending = {16'h0000, 16'h0200, 16'h0210, 16'h0212};
    run_until_idle(100);
    e = {op(0, 0), op(0, 2)};
    check_seen("resync", e);
    chk("resync_err", err, 1);
    chk("resync_err_count", err_count, 1);

    do_reset();
    out_ready = 1'b0;
    pending = {16'h0003, 16'h0004};
    repeat (3) step();
    chk("mid_queued", out_valid, 1);
    do_reset();
    out_ready = 1'b1;
    pending = {16'h0007};
    run_until_idle(100);
    e = {op(0, 7)};
    check_seen("mid_reset", e);

    do_reset();
    pending = {16'h00FF, 16'h0000, 16'h0100, 16'h0100, 16'h0000, 16'h0000};
    run_until_idle(100);
    e = {op(0, 255), op(1, 255)};
    check_seen("boundary", e);
    chk("boundary_err_count", err_count, 2);

    do_reset();
    for (int i = 0; i < 300; i++) begin
      pending.push_back(16'((i + 1) * 16'h1000));
      pending.push_back(16'((i + 1) * 16'h1000));
    end
    run_until_idle(2000);
    chk("sat_err_count", err_count, 255);
    chk("sat_err", err, 1);
    seen.delete();

    do_reset();
    last = 16'h0000;
    for (int r = 0; r < 3000; r++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (pending.size() < 3 && $urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 9))
          7:       last = last + (($urandom_range(0, 1) == 1) ? 16'd256 : -16'd256);
          8:       last = 16'($urandom);
          9:       last = last + (($urandom_range(0, 1) == 1) ? 16'd255 : -16'd255);
          default: last = last + 16'($urandom_range(0, 510)) - 16'd255;
        endcase
        pending.push_back(last);
      end
      step();
    end
    out_ready = 1'b1;
    run_until_idle(100);
    seen.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/acc_delta_decoder.md
Name: acc_delta_decoder

Overview:
- Inverse of the accumulator. Consumes the stream of accumulator values and recovers the operation stream (add_sub, data_in) that produced it.
- Takes successive ACC_W-bit values over a valid/ready input, computes the modular difference from the previous value, and emits decoded operations through a 2-entry output FIFO.
- Sits on the monitor/readback side of the accumulator datapath. Used for self-checking and for replaying operation streams.

Parameters:
- ACC_W, 16, accumulator value width.
- DATA_W, 8, operand width; must be less than ACC_W.
- INIT_VAL, 0, previous-value register contents after reset; matches the accumulator reset value.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset (asserted when 0).
- acc_in  input  ACC_W  accumulator sample.
- in_valid  input  1  acc_in is valid.
- in_ready  output  1  block can accept a sample.
- add_sub  output  1  decoded op: 0 = add, 1 = subtract.
- data_out  output  DATA_W  decoded operand.
- out_valid  output  1  head of the FIFO is valid.
- out_ready  input  1  downstream accepts the head.
- err  output  1  sticky: a delta was not representable.
- err_count  output  8  saturating count of undecodable samples.

Behaviour:
- Reset (rst==0 at a clk edge):
  - prev = INIT_VAL, FIFO emptied, state = RUN.
  - out_valid = 0, add_sub = 0, data_out = 0, err = 0, err_count = 0.
  - in_ready = 1 on the first cycle after reset.
  - Reset mid-operation discards FIFO contents and the in-flight sample.
- Input acceptance: a transfer occurs when in_valid && in_ready. in_ready = !fifo_full.
- Delta computation:
  - d = (acc_in - prev) mod 2^ACC_W.
  - n = (prev - acc_in) mod 2^ACC_W.
- State RUN, on each accepted sample:
  - d <= 2^DATA_W-1: push {add_sub=0, data=d}. d==0 decodes as add 0.
  - Else n <= 2^DATA_W-1: push {add_sub=1, data=n}.
  - Else: no push; err <= 1; err_count increments, saturating at 255; state <= RESYNC.
  - In all three cases prev <= acc_in.
- State RESYNC:
  - The next accepted sample only loads prev; no push.
  - state <= RUN.
- Wrap-around: modular arithmetic is mandatory. prev=0xFFFE, acc_in=0x0003 decodes as add 5. prev=0x0002, acc_in=0xFFFF decodes as sub 3.
- FIFO:
  - 2 entries; data_out/add_sub always show the head.
  - Latency: a sample accepted at edge k produces out_valid=1 after edge k, i.e. 1 cycle when the FIFO is empty.
  - Simultaneous push and pop while full is allowed only via pop-first. in_ready stays combinationally !full and does not look ahead on out_ready.
  - Pop occurs when out_valid && out_ready. A push into an empty FIFO does not bypass the register.
- err and err_count clear only on reset.

Decomposition:
- Package acc_pkg:
  - ACC_W/DATA_W defaults.
  - op_t struct {logic add_sub; logic [DATA_W-1:0] data}.
  - dec_state_t enum {RUN, RESYNC}.
  - Shared with the accumulator bench.
- Sub-module op_fifo2: the 2-entry synchronous FIFO of op_t with valid/ready on both sides, full/empty flags, and the same reset.
- The top level holds prev, the state machine, the delta/classification logic, and the error counters.

Test Plan:
- Basic decode: after reset, with out_ready=1, send 0x0005, 0x000F, 0x000C, 0x0008 → ops (0,5), (0,10), (1,3), (1,4), each out_valid one cycle after acceptance; err=0.
- Wrap-around: send 0xFFFE, then 0x0003 → first op is (1,2) from INIT 0; second is (0,5). Then send 0xFFFF → (1,4).
- Backpressure: hold out_ready=0 and offer 3 samples → 2 accepted and in_ready=0. Release out_ready → FIFO drains in order, the third sample is accepted, and no op is lost or duplicated.
- Error/resync: send 0x0000, 0x0200, 0x0210 → (0,0), then err=1 with err_count=1 and no op, then 0x0210 is absorbed silently. Next 0x0212 → (0,2).
- Reset mid-stream: with 2 ops queued, drive rst=0 for one edge → out_valid=0, err=0, prev=0. Then 0x0007 → (0,7).
- Boundary values: deltas of exactly +255 and -255 decode correctly; +256 and -256 raise err. err_count saturates at 255 after 300 bad samples.
